noise_log: RTL and testbench
============================

NOISE_LOG -- requirements
Module: noise_log

Interface
- REQ-001 Parameter DEPTH, default 16, SHALL set the number of stored entries; power of two, 4..256.
- REQ-002 Parameter WIDTH, default 8, SHALL set the width of a voltage sample.
- REQ-003 clk  input  1  SHALL be the single clock; all logic rising-edge.
- REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
- REQ-005 store_en  input  1  SHALL be the write request: one-cycle pulse from the upstream sweep counter when noise is detected.
- REQ-006 voltage  input  WIDTH  SHALL be the current DAC code, sampled in the store_en cycle.
- REQ-007 clear  input  1  SHALL synchronously flush buffer and flags.
- REQ-008 rd_en  input  1  SHALL be the read request from the host side.
- REQ-009 rd_data  output  WIDTH  SHALL be the registered oldest entry.
- REQ-010 rd_valid  output  1  SHALL pulse one cycle when rd_data holds a newly popped entry.
- REQ-011 empty, full  output  1 each  SHALL reflect buffer occupancy.
- REQ-012 count  output  log2(DEPTH)+1  SHALL be the current number of entries.
- REQ-013 overflow  output  1  SHALL be a sticky flag for a dropped write.
- REQ-014 first_hit  output  WIDTH  SHALL hold the voltage of the first accepted write since reset/clear.
- REQ-015 hit_valid  output  1  SHALL indicate first_hit is meaningful.

Function
- REQ-016 Accepted write: store_en=1 and (full=0, or rd_en=1 in the same cycle); voltage written at tail; tail pointer wraps modulo DEPTH.
- REQ-017 store_en=1 with full=1 and rd_en=0 SHALL drop the sample, set overflow, leave count unchanged.
- REQ-018 Accepted read: rd_en=1 and empty=0; head entry to rd_data and rd_valid=1 on the next cycle; head wraps modulo DEPTH.
- REQ-019 rd_en=1 with empty=1 SHALL be ignored: rd_valid=0, rd_data holds its previous value; no fall-through even with a simultaneous write.
- REQ-020 Simultaneous accepted read and write SHALL leave count unchanged; when full, the popped entry is the old head, not the new sample.
- REQ-021 count, empty (count==0) and full (count==DEPTH) SHALL be registered and valid in the cycle after the causing edge.
- REQ-022 On the first accepted write with hit_valid=0: first_hit takes voltage and hit_valid goes to 1; later writes do not change first_hit.
- REQ-023 overflow SHALL remain 1 until clear or reset.
- REQ-024 clear=1 SHALL take priority over store_en/rd_en in the same cycle: pointers and count to 0, overflow=0, hit_valid=0, rd_valid=0; rd_data and first_hit retain their values.
- REQ-025 Storage contents need no reset; only pointers, count and flags are reset.

Reset
- REQ-026 reset=1 SHALL force, at the next edge: count=0, empty=1, full=0, overflow=0, rd_valid=0, hit_valid=0, rd_data=0, first_hit=0, pointers=0.
- REQ-027 reset SHALL override clear, store_en and rd_en; reset mid-operation discards all stored entries.

Verification
- REQ-028 Write 0x10,0x20,0x30, then 3 reads -> rd_data 0x10,0x20,0x30 with rd_valid each; empty=1; first_hit=0x10, hit_valid=1.
- REQ-029 Write 16 values, then a 17th (0xFF) -> full=1, count=16, overflow=1; 16 reads return the first 16 values, 0xFF absent.
- REQ-030 Full buffer, store_en=1 and rd_en=1 in the same cycle -> old head popped, new value stored, count stays 16, overflow=0.
- REQ-031 Empty buffer, store_en=1 (0x42) and rd_en=1 in the same cycle -> no rd_valid, count=1; next read returns 0x42.
- REQ-032 20 write/read pairs -> pointers wrap; data order preserved, no spurious full/empty.
- REQ-033 clear asserted with store_en=1 on a 5-entry buffer -> count=0, empty=1, overflow=0, hit_valid=0; the next write sets first_hit anew.

Source files
------------

// File: rtl/noise_log_if.sv
`default_nettype none
// ============================================================================
// Module     : noise_log_if
// Description: Bundle of the noise-log FIFO write/read/status signals.
// Revision   : 1.0 - initial release
// ============================================================================
interface noise_log_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    logic                     store_en;
    logic [WIDTH-1:0]         voltage;
    logic                     clear;
    logic                     rd_en;
    logic [WIDTH-1:0]         rd_data;
    logic                     rd_valid;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [WIDTH-1:0]         first_hit;
    logic                     hit_valid;

    modport master (
        output store_en, voltage, clear, rd_en,
        input  rd_data, rd_valid, empty, full, count, overflow, first_hit, hit_valid
    );

    modport slave (
        input  store_en, voltage, clear, rd_en,
        output rd_data, rd_valid, empty, full, count, overflow, first_hit, hit_valid
    );
endinterface
`default_nettype wire

// File: rtl/noise_log.sv
`default_nettype none
// ============================================================================
// Module     : noise_log
// Description: FIFO log of DAC codes at which noise was detected, with sticky
//              overflow flag and capture of the first logged voltage.
// Revision   : 1.0 - initial release
// ============================================================================
module noise_log #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  wire             clk,
    input  wire             reset,
    noise_log_if.slave      bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_head;
    logic [c_AW-1:0]  r_tail;
    logic [c_CW-1:0]  r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_overflow;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic [WIDTH-1:0] r_first_hit;
    logic             r_hit_valid;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [c_CW-1:0]  w_count_nxt;

    // A read frees a slot in the same cycle, so a full buffer still accepts a
    // write when it is paired with a read; an empty buffer never falls through.
    assign w_rd_acc = bus.rd_en && !r_empty;
    assign w_wr_acc = bus.store_en && (!r_full || bus.rd_en);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_CW'(1);
            2'b01:   w_count_nxt = r_count - c_CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && !bus.clear && w_wr_acc) begin
            r_mem[r_tail] <= bus.voltage;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_first_hit <= '0;
            r_hit_valid <= 1'b0;
        end else if (bus.clear) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_hit_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_head];
                r_head    <= r_head + c_AW'(1);
            end
            if (w_wr_acc) begin
                r_tail <= r_tail + c_AW'(1);
                if (!r_hit_valid) begin
                    r_first_hit <= bus.voltage;
                    r_hit_valid <= 1'b1;
                end
            end
            if (bus.store_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_CW'(DEPTH));
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.first_hit = r_first_hit;
    assign bus.hit_valid = r_hit_valid;
endmodule
`default_nettype wire

// File: tb/tb_noise_log.sv
`default_nettype none
// ============================================================================
// Module     : tb_noise_log
// Description: Scoreboard bench for noise_log against a queue-based model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_noise_log;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    typedef struct {
        int         count;
        logic       empty;
        logic       full;
        logic       overflow;
        logic       rd_valid;
        logic [7:0] rd_data;
        logic [7:0] first_hit;
        logic       hit_valid;
    } status_t;

    logic clk = 1'b0;
    logic reset;

    noise_log_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    noise_log #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: plain queue of stored samples plus flags.
    logic [7:0] m_q[$];
    logic [7:0] m_rdd = 8'h00;
    logic [7:0] m_fh  = 8'h00;
    logic       m_hv  = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_rv  = 1'b0;

    status_t    sq[$];
    logic [7:0] dq[$];

    task automatic model_step(input logic se, input logic [7:0] v, input logic cl,
                              input logic re, input logic rs);
        logic rd, wr;
        status_t s;
        if (rs) begin
            m_q.delete(); m_ovf = 0; m_hv = 0; m_fh = 0; m_rdd = 0; m_rv = 0;
        end else if (cl) begin
            m_q.delete(); m_ovf = 0; m_hv = 0; m_rv = 0;
        end else begin
            rd = re && (m_q.size() != 0);
            wr = se && ((m_q.size() < DEPTH) || re);
            m_rv = rd;
            if (rd) begin
                m_rdd = m_q.pop_front();
                dq.push_back(m_rdd);
            end
            if (wr) begin
                m_q.push_back(v);
                if (!m_hv) begin
                    m_hv = 1; m_fh = v;
                end
            end
            if (se && !wr) m_ovf = 1;
        end
        s.count     = m_q.size();
        s.empty     = (m_q.size() == 0);
        s.full      = (m_q.size() == DEPTH);
        s.overflow  = m_ovf;
        s.rd_valid  = m_rv;
        s.rd_data   = m_rdd;
        s.first_hit = m_fh;
        s.hit_valid = m_hv;
        sq.push_back(s);
    endtask

    task automatic cyc(input logic se, input logic [7:0] v, input logic cl,
                       input logic re, input logic rs);
        @(negedge clk);
        bus.store_en = se;
        bus.voltage  = v;
        bus.clear    = cl;
        bus.rd_en    = re;
        reset        = rs;
        model_step(se, v, cl, re, rs);
    endtask

    task automatic wr(input logic [7:0] v);  cyc(1, v, 0, 0, 0); endtask
    task automatic rd();                     cyc(0, 8'h00, 0, 1, 0); endtask
    task automatic idle();                   cyc(0, 8'h00, 0, 0, 0); endtask
    task automatic clr();                    cyc(0, 8'h00, 1, 0, 0); endtask

    // Monitor: one expected status per clock edge; popped data on rd_valid.
    initial begin
        status_t    e;
        logic [7:0] d;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() != 0) begin
                e = sq.pop_front();
                n_tests++;
                if (int'(bus.count) != e.count || bus.empty !== e.empty || bus.full !== e.full ||
                    bus.overflow !== e.overflow || bus.rd_valid !== e.rd_valid ||
                    bus.rd_data !== e.rd_data || bus.first_hit !== e.first_hit ||
                    bus.hit_valid !== e.hit_valid) begin
                    n_fail++;
                    $display("FAIL status t=%0t got cnt=%0d e=%b f=%b ovf=%b rv=%b rd=%h fh=%h hv=%b want cnt=%0d e=%b f=%b ovf=%b rv=%b rd=%h fh=%h hv=%b",
                             $time, bus.count, bus.empty, bus.full, bus.overflow, bus.rd_valid,
                             bus.rd_data, bus.first_hit, bus.hit_valid, e.count, e.empty, e.full,
                             e.overflow, e.rd_valid, e.rd_data, e.first_hit, e.hit_valid);
                end
                if (bus.rd_valid === 1'b1) begin
                    n_tests++;
                    if (dq.size() == 0) begin
                        n_fail++;
                        $display("FAIL pop t=%0t got rd_valid with data %h required no pop", $time, bus.rd_data);
                    end else begin
                        d = dq.pop_front();
                        if (bus.rd_data !== d) begin
                            n_fail++;
                            $display("FAIL pop_data t=%0t got %h required %h", $time, bus.rd_data, d);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bus.store_en = 0; bus.voltage = 0; bus.clear = 0; bus.rd_en = 0; reset = 1;
        cyc(0, 8'h00, 0, 0, 1);
        cyc(1, 8'h55, 1, 1, 1);
        idle();

        // Three writes then three reads
        wr(8'h10); wr(8'h20); wr(8'h30);
        rd(); rd(); rd(); idle();

        // Fill, overflow drop, drain
        clr();
        for (int i = 0; i < DEPTH; i++) wr(8'(i * 3 + 1));
        wr(8'hFF);
        for (int i = 0; i < DEPTH; i++) rd();
        idle();

        // Full buffer with simultaneous read and write
        clr();
        for (int i = 0; i < DEPTH; i++) wr(8'(8'hA0 + i));
        cyc(1, 8'h77, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) rd();
        idle();

        // Empty buffer with simultaneous read and write: no fall-through
        cyc(1, 8'h42, 0, 1, 0);
        rd(); idle();

        // Write/read pairs wrap the pointers
        for (int i = 0; i < 20; i++) begin
            wr(8'(8'hC0 + i));
            rd();
        end
        idle();

        // Clear beats a simultaneous store, then first_hit is captured anew
        for (int i = 0; i < 5; i++) wr(8'(8'h50 + i));
        cyc(1, 8'hEE, 1, 0, 0);
        wr(8'h99); rd(); idle();

        // Reset in the middle of operation discards entries
        wr(8'h01); wr(8'h02); wr(8'h03);
        cyc(1, 8'h04, 0, 1, 1);
        rd(); idle();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, 8'($urandom),
                ($urandom_range(0, 127) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                ($urandom_range(0, 511) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < DEPTH + 2; i++) rd();
        idle(); idle();

        @(negedge clk);
        n_tests++;
        if (sq.size() != 0 || dq.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d status %0d data left required 0 0", sq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
